// File: rtl/logic_gate_unit_if.sv
// Operand/result stream bundle for logic_gate_unit: operand beat in, result beat out.
// slave = the unit itself, master = whoever feeds operands and drains results.
interface logic_gate_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_red;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, y_red
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, y_red
  );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready streams and a 2-entry output buffer.
// Define LGU_STATS_EN to add the beat_count and stall_flag status outputs.
module logic_gate_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RED_OP = 0
) (
  input  logic             clk,
  input  logic             rst,
  logic_gate_unit_if.slave bus
`ifdef LGU_STATS_EN
  ,
  output logic [15:0]      beat_count,
  output logic             stall_flag
`endif
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  typedef struct packed {
    logic             red;
    logic [WIDTH-1:0] data;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept;
  logic             emit;
  logic [WIDTH-1:0] result_data;
  entry_t           result;

  // RED_OP values other than 1 and 2 fall back to parity.
  function automatic logic reduce(input logic [WIDTH-1:0] v);
    if (RED_OP == 1)      return &v;
    else if (RED_OP == 2) return |v;
    else                  return ^v;
  endfunction

  always_comb begin
    case (bus.op)
      3'b000:  result_data = bus.a & bus.b;
      3'b001:  result_data = bus.a | bus.b;
      3'b010:  result_data = ~(bus.a & bus.b);
      3'b011:  result_data = ~(bus.a | bus.b);
      3'b100:  result_data = bus.a ^ bus.b;
      3'b101:  result_data = ~(bus.a ^ bus.b);
      3'b110:  result_data = ~bus.a;
      default: result_data = bus.a;
    endcase
  end

  // Reduction is formed with the data so the stored pair is always coherent.
  always_comb begin
    result.data = result_data;
    result.red  = reduce(result_data);
  end

  assign accept = bus.in_valid & in_ready_q;
  assign emit   = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = result;
        end
      end
      ONE: begin
        if (accept && emit) begin
          head_d = result;
        end else if (accept) begin
          state_d = TWO;
          skid_d  = result;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next state, so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = head_q.data;
  assign bus.y_red     = head_q.red;

`ifdef LGU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (emit) beat_count <= beat_count + 16'd1;
      stall_flag <= out_valid_q & ~bus.out_ready;
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: a capacity-2 result FIFO model with per-bit truth tables,
// plus directed truth sweeps, a WIDTH=1 NAND instance, backpressure, reset and (optionally) stats checks.
module tb_logic_gate_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_gate_unit_if #(.WIDTH(8)) bus8 ();
  logic_gate_unit_if #(.WIDTH(1)) bus1 ();

`ifdef LGU_STATS_EN
  logic [15:0] beat_count8, beat_count1;
  logic        stall_flag8, stall_flag1;
`endif

  logic_gate_unit #(.WIDTH(8), .RED_OP(0)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus8)
`ifdef LGU_STATS_EN
    ,
    .beat_count (beat_count8),
    .stall_flag (stall_flag8)
`endif
  );

  logic_gate_unit #(.WIDTH(1), .RED_OP(0)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus1)
`ifdef LGU_STATS_EN
    ,
    .beat_count (beat_count1),
    .stall_flag (stall_flag1)
`endif
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          obs_emit = 0;
  logic [3:0]  lut [8];
  logic [8:0]  q8 [$];
  logic [15:0] exp_beats = '0;
  bit          prev_stall = 1'b0;
  bit          acc;
  logic [8:0]  tab_f0 [8];
  logic [8:0]  tab_01 [3];
  logic        nand_exp [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: each result bit looked up in a 4-entry truth table indexed by {a_bit, b_bit}.
  function automatic logic [8:0] ref8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    logic [7:0] r;
    int         ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      r[i] = lut[o][{x[i], z[i]}];
      if (r[i]) ones++;
    end
    return {((ones % 2) == 1), r};
  endfunction

  // One clock cycle on the WIDTH=8 unit: drive, check at negedge against the model, advance the model.
  task automatic cycle8(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] z,
                        input logic rdy, input bit dchk, input logic [8:0] dexp, output bit accepted);
    bit         em;
    logic [8:0] hd;
    bus8.in_valid  = v;
    bus8.op        = o;
    bus8.a         = x;
    bus8.b         = z;
    bus8.out_ready = rdy;
    @(negedge clk);
    check("out_valid", 32'(bus8.out_valid), 32'(q8.size() != 0));
    check("in_ready", 32'(bus8.in_ready), 32'(q8.size() < 2));
    if (q8.size() != 0) begin
      hd = q8[0];
      check("y", 32'(bus8.y), 32'(hd[7:0]));
      check("y_red", 32'(bus8.y_red), 32'(hd[8]));
    end
    if (dchk) begin
      check("directed_y", 32'(bus8.y), 32'(dexp[7:0]));
      check("directed_y_red", 32'(bus8.y_red), 32'(dexp[8]));
    end
`ifdef LGU_STATS_EN
    check("beat_count", 32'(beat_count8), 32'(exp_beats));
    check("stall_flag", 32'(stall_flag8), 32'(prev_stall));
`endif
    if (bus8.out_valid && rdy) obs_emit++;
    accepted   = v && (q8.size() < 2);
    em         = (q8.size() != 0) && rdy;
    prev_stall = (q8.size() != 0) && !rdy;
    @(posedge clk);
    #1;
    if (em) begin
      void'(q8.pop_front());
      exp_beats = exp_beats + 16'd1;
    end
    if (accepted) q8.push_back(ref8(o, x, z));
  endtask

  task automatic clear_model();
    q8.delete();
    exp_beats  = '0;
    prev_stall = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int start_emit;
    lut[0] = 4'b1000; lut[1] = 4'b1110; lut[2] = 4'b0111; lut[3] = 4'b0001;
    lut[4] = 4'b0110; lut[5] = 4'b1001; lut[6] = 4'b0011; lut[7] = 4'b1100;
    tab_f0 = '{9'h0C0, 9'h0FC, 9'h03F, 9'h003, 9'h03C, 9'h0C3, 9'h00F, 9'h0F0};
    tab_01 = '{9'h000, 9'h101, 9'h0FF};
    nand_exp = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.op = '0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst8_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst8_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst8_y", 32'(bus8.y), 32'd0);
    check("rst8_y_red", 32'(bus8.y_red), 32'd0);
    check("rst1_out_valid", 32'(bus1.out_valid), 32'd0);
    check("rst1_in_ready", 32'(bus1.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // WIDTH=1 NAND equivalence, (a,b) = 00, 01, 10, 11
    bus1.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus1.in_valid = (k < 4);
      bus1.op       = 3'b010;
      bus1.a        = 1'((k >> 1) & 1);
      bus1.b        = 1'(k & 1);
      @(negedge clk);
      if (k > 0) begin
        check("nand1_valid", 32'(bus1.out_valid), 32'd1);
        check("nand1_y", 32'(bus1.y), 32'(nand_exp[k-1]));
        check("nand1_y_red", 32'(bus1.y_red), 32'(nand_exp[k-1]));
      end
      @(posedge clk);
      #1;
    end
    bus1.in_valid = 1'b0;

    // Truth sweeps
    for (int i = 0; i <= 8; i++)
      cycle8(i < 8, 3'(i), 8'hF0, 8'hCC, 1'b1, i > 0, tab_f0[(i > 0) ? i - 1 : 0], acc);
    for (int i = 0; i <= 3; i++)
      cycle8(i < 3, 3'(i), 8'h01, 8'h00, 1'b1, i > 0, tab_01[(i > 0) ? i - 1 : 0], acc);

    // Backpressure: third beat refused until the buffer drains, results in order with no gap
    cycle8(1'b1, 3'b111, 8'd1, 8'd0, 1'b0, 1'b0, '0, acc);
    cycle8(1'b1, 3'b111, 8'd2, 8'd0, 1'b0, 1'b0, '0, acc);
    cycle8(1'b1, 3'b111, 8'd3, 8'd0, 1'b0, 1'b0, '0, acc);
    cycle8(1'b1, 3'b111, 8'd3, 8'd0, 1'b1, 1'b1, 9'h101, acc);
    cycle8(1'b1, 3'b111, 8'd3, 8'd0, 1'b1, 1'b1, 9'h102, acc);
    cycle8(1'b0, 3'b111, 8'd0, 8'd0, 1'b1, 1'b1, 9'h003, acc);
    cycle8(1'b0, 3'b000, 8'd0, 8'd0, 1'b1, 1'b0, '0, acc);

    // Full throughput
    start_emit = obs_emit;
    for (int i = 0; i < 100; i++)
      cycle8(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, '0, acc);
    cycle8(1'b0, 3'b000, 8'd0, 8'd0, 1'b1, 1'b0, '0, acc);
    check("throughput_emits", 32'(obs_emit - start_emit), 32'd100);

    // Random valid/ready mix
    for (int i = 0; i < 400; i++)
      cycle8(($urandom % 4) != 0, 3'($urandom), 8'($urandom), 8'($urandom),
             ($urandom % 3) != 0, 1'b0, '0, acc);
    repeat (3) cycle8(1'b0, 3'b000, 8'd0, 8'd0, 1'b1, 1'b0, '0, acc);

    // Reset with the buffer full
    cycle8(1'b1, 3'b000, 8'h0F, 8'hFF, 1'b0, 1'b0, '0, acc);
    cycle8(1'b1, 3'b001, 8'h30, 8'h03, 1'b0, 1'b0, '0, acc);
    check("pre_rst_full", 32'(bus8.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_mid_y", 32'(bus8.y), 32'd0);
    check("rst_mid_y_red", 32'(bus8.y_red), 32'd0);
    check("rst_mid_in_ready", 32'(bus8.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    cycle8(1'b1, 3'b100, 8'hAA, 8'h55, 1'b1, 1'b0, '0, acc);
    cycle8(1'b0, 3'b000, 8'd0, 8'd0, 1'b1, 1'b1, 9'h0FF, acc);

`ifdef LGU_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_model();
    for (int i = 0; i < 65537; i++)
      cycle8(1'b1, 3'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0, '0, acc);
    cycle8(1'b0, 3'b000, 8'd0, 8'd0, 1'b1, 1'b0, '0, acc);
    @(negedge clk);
    check("beat_count_wrap", 32'(beat_count8), 32'd1);
    @(posedge clk);
    #1;
    cycle8(1'b1, 3'b000, 8'h33, 8'h33, 1'b1, 1'b0, '0, acc);
    cycle8(1'b0, 3'b000, 8'd0, 8'd0, 1'b0, 1'b0, '0, acc);
    @(negedge clk);
    check("stall_flag_set", 32'(stall_flag8), 32'd1);
    @(posedge clk);
    #1;
    prev_stall = 1'b1;
    cycle8(1'b0, 3'b000, 8'd0, 8'd0, 1'b1, 1'b0, '0, acc);
    cycle8(1'b0, 3'b000, 8'd0, 8'd0, 1'b1, 1'b0, '0, acc);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
